// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: resynchronises an OutD/OutC serial pair and
// reassembles each frame (address MSB-first, then data MSB-first) into
// parallel words. It also flags a device-address match and aborts
// truncated frames after a period of serial-clock inactivity.
module serial_frame_receiver #(
  parameter int              A_W      = 7,
  parameter int              D_W      = 8,
  parameter logic [A_W-1:0]  DEV_ADDR = 7'h55,
  parameter int              TIMEOUT  = 64
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           ser_d,
  input  logic           ser_c,
  output logic [A_W-1:0] addr_out,
  output logic [D_W-1:0] data_out,
  output logic           valid,
  output logic           addr_hit,
  output logic           frame_err,
  output logic           busy
);

  localparam int F_W = A_W + D_W;
  localparam int CW  = $clog2(F_W + 1);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic {IDLE, SHIFT} state_t;

  // synchroniser and edge-detect flops
  logic c1_q, c2_q, c3_q, d1_q, d2_q;
  logic rise;

  state_t          st_q, st_d;
  logic [F_W-1:0]  sr_q, sr_d, sr_nxt;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [A_W-1:0]  addr_q, addr_d;
  logic [D_W-1:0]  data_q, data_d;
  logic            valid_q, valid_d;
  logic            hit_q, hit_d;
  logic            ferr_q, ferr_d;

  // Both serial lines are resynchronised with equal depth, so that d2 is
  // aligned with the cycle in which the rising edge of c2 is seen.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      c1_q <= 1'b0; c2_q <= 1'b0; c3_q <= 1'b0;
      d1_q <= 1'b0; d2_q <= 1'b0;
    end else begin
      c1_q <= ser_c; c2_q <= c1_q; c3_q <= c2_q;
      d1_q <= ser_d; d2_q <= d1_q;
    end
  end

  assign rise   = c2_q & ~c3_q;
  assign sr_nxt = {sr_q[F_W-2:0], d2_q};

  // Frame FSM next-state: shift on each rise, complete on the last bit,
  // and abort on inactivity.
  always_comb begin
    st_d     = st_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    hit_d    = 1'b0;
    ferr_d   = 1'b0;
    case (st_q)
      IDLE: begin
        if (rise) begin
          sr_d     = sr_nxt;
          bitcnt_d = CW'(1);
          tcnt_d   = '0;
          st_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          sr_d   = sr_nxt;
          tcnt_d = '0;
          if (bitcnt_q == CW'(F_W - 1)) begin
            addr_d   = sr_nxt[F_W-1:D_W];
            data_d   = sr_nxt[D_W-1:0];
            valid_d  = 1'b1;
            hit_d    = (sr_nxt[F_W-1:D_W] == DEV_ADDR);
            bitcnt_d = '0;
            st_d     = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // Truncated frame: drop the partial bits, keep the last good word.
          ferr_d   = 1'b1;
          bitcnt_d = '0;
          tcnt_d   = '0;
          st_d     = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Frame FSM state and registered outputs; reset wins over any event.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      st_q     <= IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      tcnt_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      hit_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      hit_q    <= hit_d;
      ferr_q   <= ferr_d;
    end
  end

  assign addr_out  = addr_q;
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign addr_hit  = hit_q;
  assign frame_err = ferr_q;
  assign busy      = (st_q == SHIFT);

endmodule
